// File: rtl/uart_rx_fifo_if.sv
// Serial input and buffered-byte consumer signals of uart_rx_fifo.
// slave = the receiver; master = the line driver / byte consumer.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          i_rx_serial;
  logic          i_rd;
  logic [7:0]    o_rx_data;
  logic          o_rx_valid;
  logic          o_rx_active;
  logic          o_frame_err;
  logic          o_parity_err;
  logic          o_overrun;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_rx_serial, i_rd,
    output o_rx_data, o_rx_valid, o_rx_active, o_frame_err,
           o_parity_err, o_overrun, o_count
  );

  modport master (
    output i_rx_serial, i_rd,
    input  o_rx_data, o_rx_valid, o_rx_active, o_frame_err,
           o_parity_err, o_overrun, o_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity bit after the data).
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 2604,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_rx_fifo_if.slave bus
);
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_V0   = CNT_W'(CLK_PER_BIT - 3);
  localparam logic [CNT_W-1:0] CNT_V1   = CNT_W'(CLK_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_v0, r_v1;
  logic             r_active;
  logic             r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bad;
  logic             r_parity_err;
`endif

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overrun;

  logic w_rx, w_bit_end, w_vote, w_push, w_pop, w_wr_en, w_full, w_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.i_rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx      = r_sync2;
  assign w_bit_end = (r_cnt == CNT_LAST);
  // Two stored samples plus the live one form the 2-of-3 vote at the bit wrap.
  assign w_vote    = (r_v0 & r_v1) | (r_v0 & w_rx) | (r_v1 & w_rx);

`ifdef UART_RX_PARITY_EN
  assign w_push = (r_state == S_STOP) && w_bit_end && w_vote && !r_par_bad;
`else
  assign w_push = (r_state == S_STOP) && w_bit_end && w_vote;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_v0         <= 1'b1;
      r_v1         <= 1'b1;
      r_active     <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (r_cnt == CNT_V0) r_v0 <= w_rx;
      if (r_cnt == CNT_V1) r_v1 <= w_rx;
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state  <= S_START;
            r_cnt    <= '0;
            r_active <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
          end
        end
        S_START: begin
          // Restarting the counter at mid start bit puts every later wrap near a bit centre.
          if (r_cnt == CNT_HALF) begin
            if (w_rx) begin
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_shift   <= {w_vote, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_par_bad <= (w_vote != ^r_shift);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= r_par_bad;
`endif
            if (w_vote) begin
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (w_rx) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.i_rd && !w_empty;
  // When full, a same-cycle pop frees the head slot, which is exactly where the write lands.
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)   r_rptr <= r_rptr + PTR_W'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_wr_en) r_count <= r_count - CW'(1);
      if (w_push && !w_wr_en) r_overrun <= 1'b1;
    end
  end

  assign bus.o_rx_data   = w_empty ? 8'h00 : r_mem[r_rptr];
  assign bus.o_rx_valid  = !w_empty;
  assign bus.o_rx_active = r_active;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_overrun   = r_overrun;
  assign bus.o_count     = r_count;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = r_parity_err;
`else
  assign bus.o_parity_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampling UART receiver with a byte FIFO, the receiving end of the team's UART transmitter on the shared serial line. It recovers 8N1 frames (or 8E1 with parity built in), votes each bit at its midpoint and rejects glitches and bad frames. It buffers good bytes for a downstream consumer through a first-word-fall-through valid/read interface. It replaces single-byte handshake reception where the consumer cannot service every byte within one frame time.

## Interface
- CLK_PER_BIT, 2604, clock cycles per bit (CLK_FREQ/BAUDRATE); minimum 8.
- FIFO_DEPTH, 4, byte entries; power of two, minimum 2.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_serial  in  1  asynchronous serial line, idle high.
- i_rd  in  1  pop head byte; ignored when o_rx_valid=0.
- o_rx_data  out  8  FIFO head byte; valid only while o_rx_valid=1.
- o_rx_valid  out  1  FIFO not empty.
- o_rx_active  out  1  frame in progress (any state but IDLE).
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_parity_err  out  1  one-cycle pulse: parity mismatch.
- o_overrun  out  1  sticky: a good byte was dropped because the FIFO was full; cleared only by i_rst.
- o_count  out  $clog2(FIFO_DEPTH+1)  bytes held.

## Operation
- Input passes a 2-FF synchronizer (both stages reset to 1); all decisions use the synchronized bit.
- Bit counter counts 0..CLK_PER_BIT-1. Majority vote over synced samples at counts CLK_PER_BIT-3, -2, -1; the bit is decided at the wrap.
- States and transitions:
  - IDLE: synced line low -> START, counter 0.
  - START: at count CLK_PER_BIT/2-1, if the line is high (glitch) -> IDLE with no error. Otherwise counter 0 -> DATA. This aligns later votes to bit midpoints.
  - DATA: 8 bits, LSB first, into a shift register -> PARITY (if built) else STOP.
  - PARITY: vote expected-parity bit -> STOP.
  - STOP: vote 1 -> push byte -> IDLE. Vote 0 -> o_frame_err pulse, byte discarded -> BREAK.
  - BREAK: wait for synced line high -> IDLE. This prevents a held-low line re-triggering.
- Push while full: byte dropped, o_overrun set, count unchanged.
- Push and pop in the same cycle: both occur and the count is unchanged. This holds when full: no overrun.
- Pop when empty: no effect.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Empty/full are derived from o_count.

## Timing
- Reset values: o_rx_data 0, o_rx_valid 0, o_rx_active 0, o_frame_err 0, o_parity_err 0, o_overrun 0, o_count 0. State is IDLE and the FIFO is empty.
- Reset mid-frame aborts the frame; no byte and no error are produced.
- Line fall to START: 3 cycles (2 sync + state register).
- Stop-bit decision cycle C: the FIFO write and the count update are visible at C+1. o_rx_valid rises at C+1 if the FIFO was empty.
- o_rx_data is combinational from the head entry. After an i_rd pop at cycle P, the next byte (or o_rx_valid=0) appears at P+1.
- Error pulses are high exactly one cycle, at C+1.
- o_rx_active falls at C+1 and rises 3 cycles after the start edge.
- Back-to-back frames with a full-length stop bit are received without loss.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state is built and one even-parity bit follows the data. A mismatch pulses o_parity_err and discards the byte; the stop bit is still checked. A frame with both errors pulses both.
- UART_RX_PARITY_EN undefined: there is no PARITY state, the frame is 8N1, and o_parity_err is tied 0.

## Test plan
- CLK_PER_BIT=16, send 8'hAB 8N1 -> o_rx_valid rises, o_rx_data=8'hAB, o_count=1. i_rd pulse -> o_rx_valid=0, o_count=0.
- Low glitch of 6 cycles (CLK_PER_BIT=16) -> no byte, no error, o_rx_active returns 0.
- Frame 8'h55 with stop bit driven low then line held low 40 cycles -> one o_frame_err pulse, o_count=0. The next good frame 8'h3C is received.
- Send 5 bytes 01..05 without reading, FIFO_DEPTH=4 -> o_overrun=1, o_count=4, reads return 01,02,03,04.
- With FIFO full, pop in the same cycle as the 5th push -> o_overrun stays 0 and o_count stays 4.
- UART_RX_PARITY_EN: 8'hAB with parity 1 (correct) -> byte accepted. Parity 0 -> o_parity_err pulse, no byte. Also, assert i_rst mid-DATA -> all outputs 0, the following frame is received normally.
